// File: rtl/servo_pkg.sv
// servo_pkg -- shared definitions for the servo position path.
//
// Holds the position and step widths and the ramp controller state
// encoding. The PWM stage imports this package too, so both sides agree on
// the duty-cycle width.
//
// Contents:
//   POS_W          position / duty-cycle width (8)
//   STEP_W         per-frame step size width (4)
//   servo_state_t  ramp controller states IDLE / RAMP
package servo_pkg;

    localparam int POS_W  = 8;
    localparam int STEP_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } servo_state_t;

endpackage

// File: rtl/servo_frame_timer.sv
// servo_frame_timer -- free-running frame counter for the servo ramp.
//
// Counts 0..FRAME_CLKS-1 and wraps. frame_o is high for the single cycle in
// which the count sits at FRAME_CLKS-1, so the next clock edge is the frame
// boundary where position updates are applied.
//
// Parameters:
//   FRAME_CLKS  clk cycles per frame (>= 2)
// Ports:
//   clk      clock
//   rst      synchronous reset, active-low (count returns to 0)
//   frame_o  one-cycle frame boundary pulse
module servo_frame_timer
    import servo_pkg::*;
#(
    parameter int FRAME_CLKS = 238000
) (
    input  logic clk,
    input  logic rst,
    output logic frame_o
);

    localparam int              CNT_W = (FRAME_CLKS > 2) ? $clog2(FRAME_CLKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CLKS - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Decoded from the count register; 0 while in reset because the count is 0.
    assign frame_o = (cnt == LAST);

endmodule

// File: rtl/servo_ramp.sv
// servo_ramp -- rate-limited servo position controller.
//
// Accepts a target position through a valid/ready handshake and walks the
// registered duty cycle toward it by at most step_i per frame. Position
// changes only on frame boundaries. While a ramp is in progress new targets
// are refused (tgt_ready_o low).
//
// Optional build macro:
//   SERVO_RAMP_CLAMP_EN  when defined, accepted targets are clamped to
//                        [MIN_POS, MAX_POS]; otherwise they latch unmodified.
//
// Parameters:
//   FRAME_CLKS  clk cycles per frame (>= 2)
//   INIT_POS    duty cycle / target after reset
//   MIN_POS     lower clamp bound (clamp build only)
//   MAX_POS     upper clamp bound (clamp build only)
// Ports:
//   clk           clock
//   rst           synchronous reset, active-low
//   tgt_i         requested target position
//   tgt_valid_i   tgt_i valid
//   tgt_ready_o   target can be accepted (controller idle)
//   step_i        max position change per frame, 0 means 1
//   duty_cycle_o  registered position to the PWM stage
//   busy_o        high while ramping
//   frame_o       one-cycle frame boundary pulse
module servo_ramp
    import servo_pkg::*;
#(
    parameter int FRAME_CLKS = 238000,
    parameter int INIT_POS   = 128,
    parameter int MIN_POS    = 0,
    parameter int MAX_POS    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [POS_W-1:0]  tgt_i,
    input  logic              tgt_valid_i,
    output logic              tgt_ready_o,
    input  logic [STEP_W-1:0] step_i,
    output logic [POS_W-1:0]  duty_cycle_o,
    output logic              busy_o,
    output logic              frame_o
);

    if (!((MIN_POS <= INIT_POS) && (INIT_POS <= MAX_POS) && (FRAME_CLKS >= 2))) begin : g_bad_cfg
        $error("servo_ramp: require MIN_POS <= INIT_POS <= MAX_POS and FRAME_CLKS >= 2");
    end

    // Saturate an accepted target into the allowed travel range.
    function automatic logic [POS_W-1:0] clamp_tgt(input logic [POS_W-1:0] t);
`ifdef SERVO_RAMP_CLAMP_EN
        if (t < POS_W'(MIN_POS)) begin
            return POS_W'(MIN_POS);
        end else if (t > POS_W'(MAX_POS)) begin
            return POS_W'(MAX_POS);
        end
        return t;
`else
        return t;
`endif
    endfunction

    // One frame's move from cur toward tgt. The difference is taken in
    // POS_W+1 signed bits so both directions are exact; when the remaining
    // distance is within one step the result lands exactly on tgt, so the
    // position never overshoots or wraps.
    function automatic logic [POS_W-1:0] step_toward(input logic [POS_W-1:0]  cur,
                                                     input logic [POS_W-1:0]  tgt,
                                                     input logic [STEP_W-1:0] stp);
        logic signed [POS_W:0] diff;
        logic signed [POS_W:0] mag;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        mag  = (stp == '0) ? (POS_W+1)'(1) : $signed((POS_W+1)'(stp));
        if (diff > mag) begin
            return cur + mag[POS_W-1:0];
        end else if (diff < -mag) begin
            return cur - mag[POS_W-1:0];
        end
        return tgt;
    endfunction

    servo_state_t     state;
    logic [POS_W-1:0] duty;
    logic [POS_W-1:0] target;
    logic [POS_W-1:0] tgt_acc;
    logic [POS_W-1:0] duty_nxt;
    logic             busy_r;
    logic             ready_r;
    logic             frame;

    servo_frame_timer #(
        .FRAME_CLKS (FRAME_CLKS)
    ) u_frame_timer (
        .clk     (clk),
        .rst     (rst),
        .frame_o (frame)
    );

    assign tgt_acc  = clamp_tgt(tgt_i);
    assign duty_nxt = step_toward(duty, target, step_i);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            duty    <= POS_W'(INIT_POS);
            target  <= POS_W'(INIT_POS);
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            unique case (state)
                // A transfer only latches the target; even on a frame edge the
                // first step waits for the next frame.
                IDLE: begin
                    if (tgt_valid_i && ready_r) begin
                        target <= tgt_acc;
                        if (tgt_acc != duty) begin
                            state   <= RAMP;
                            busy_r  <= 1'b1;
                            ready_r <= 1'b0;
                        end
                    end
                end
                RAMP: begin
                    if (frame) begin
                        duty <= duty_nxt;
                        if (duty_nxt == target) begin
                            state   <= IDLE;
                            busy_r  <= 1'b0;
                            ready_r <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign duty_cycle_o = duty;
    assign busy_o       = busy_r;
    assign tgt_ready_o  = ready_r;
    assign frame_o      = frame;

endmodule

// File: tb/tb_servo_ramp.sv
`timescale 1ns/1ps
module tb_servo_ramp;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tgt = 8'd0;
    logic       tgt_valid = 1'b0;
    logic       tgt_ready;
    logic [3:0] step = 4'd0;
    logic [7:0] duty;
    logic       busy;
    logic       frame;

    always #5 clk = ~clk;

    servo_ramp #(
        .FRAME_CLKS (10),
        .INIT_POS   (128),
        .MIN_POS    (50),
        .MAX_POS    (200)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tgt_i        (tgt),
        .tgt_valid_i  (tgt_valid),
        .tgt_ready_o  (tgt_ready),
        .step_i       (step),
        .duty_cycle_o (duty),
        .busy_o       (busy),
        .frame_o      (frame)
    );

    typedef struct {
        logic [7:0] duty;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input int d, input bit b);
        exp_t e;
        e.duty = d[7:0];
        e.busy = b;
        exp_q.push_back(e);
    endtask

    // Monitor: a frame edge seen with busy high is a step; pop and compare
    // after it. Any other edge outside reset must leave the duty unchanged.
    bit         mon_pending = 1'b0;
    bit         mon_prev_rst = 1'b0;
    logic [7:0] mon_prev_duty = 8'd0;
    exp_t       mon_e;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_pending) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_step: got %0d, expected no step from %0d", duty, mon_prev_duty);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("step_duty", duty, mon_e.duty);
                    check("step_busy", busy, mon_e.busy);
                    check("step_ready", tgt_ready, !mon_e.busy);
                end
            end else if (mon_prev_rst) begin
                check("duty_hold", duty, mon_prev_duty);
            end
            mon_pending   = rst && frame && busy;
            mon_prev_rst  = rst;
            mon_prev_duty = duty;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Two reset edges; returns just after the last one with rst released.
    task automatic apply_reset();
        @(posedge clk); #2;
        rst = 1'b0;
        tgt_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_duty", duty, 128);
        check("rst_busy", busy, 0);
        check("rst_frame", frame, 0);
        @(posedge clk); #2;
        rst = 1'b1;
    endtask

    task automatic send(input logic [7:0] t);
        bit ok;
        ok = 1'b0;
        tgt = t;
        tgt_valid = 1'b1;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge clk);
            ok = tgt_ready;
            @(posedge clk); #2;
        end
        tgt_valid = 1'b0;
        check("send_accepted", ok, 1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && tgt_ready;
        end
        check("ramp_finished", done, 1);
    endtask

    task automatic wait_q_empty();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge clk);
            done = (exp_q.size() == 0);
        end
        check("steps_seen", done, 1);
    endtask

    initial begin
        bit seen;

        // Reset state and first frame timing.
        apply_reset();
        @(negedge clk);
        check("post_rst_duty", duty, 128);
        check("post_rst_ready", tgt_ready, 1);
        check("post_rst_busy", busy, 0);
        check("frame_cnt0", frame, 0);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check("frame_timing", frame, (i == 9) ? 1 : 0);
        end

        // Ramp up 128 -> 138 by 3.
        step = 4'd3;
        push(131, 1); push(134, 1); push(137, 1); push(138, 0);
        send(8'd138);
        wait_idle();
        check("up_final", duty, 138);

        // Ramp down 128 -> 120 with step 0 treated as 1.
        apply_reset();
        step = 4'd0;
        for (int d = 127; d >= 121; d--) push(d, 1);
        push(120, 0);
        send(8'd120);
        wait_idle();
        check("down_final", duty, 120);

        // Target offered mid-ramp is held off until idle.
        apply_reset();
        step = 4'd3;
        push(131, 1); push(134, 0);
        send(8'd134);
        tgt = 8'd200;
        tgt_valid = 1'b1;
        push(145, 1); push(156, 1); push(167, 1); push(178, 1); push(189, 1); push(200, 0);
        @(negedge clk);
        check("ready_in_ramp", tgt_ready, 0);
        check("busy_in_ramp", busy, 1);
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            if (n > 0) @(negedge clk);
            seen = tgt_ready;
        end
        check("first_idle_seen", seen, 1);
        check("first_idle_duty", duty, 134);
        @(posedge clk); #2;
        tgt_valid = 1'b0;
        step = 4'd11;
        @(negedge clk);
        check("held_accepted", busy, 1);
        check("held_duty", duty, 134);
        wait_idle();
        check("held_final", duty, 200);

        // Transfer aligned with a frame edge, large step, no wrap at 255.
        apply_reset();
        step = 4'd15;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = frame;
        end
        check("frame_found", seen, 1);
        @(posedge clk);
        repeat (9) @(posedge clk);
        #2;
        tgt = 8'd255;
        tgt_valid = 1'b1;
        for (int d = 143; d <= 248; d += 15) push(d, 1);
        push(255, 0);
        @(negedge clk);
        check("aligned_frame", frame, 1);
        check("aligned_ready", tgt_ready, 1);
        @(posedge clk); #2;
        tgt_valid = 1'b0;
        @(negedge clk);
        check("aligned_busy", busy, 1);
        check("aligned_no_step", duty, 128);
        wait_idle();
        check("top_final", duty, 255);

        // Out-of-range target: clamped in the clamp build, raw otherwise.
        apply_reset();
        step = 4'd15;
`ifdef SERVO_RAMP_CLAMP_EN
        push(143, 1); push(158, 1); push(173, 1); push(188, 1); push(200, 0);
        send(8'd250);
        wait_idle();
        check("clamp_final", duty, 200);
`else
        for (int d = 143; d <= 248; d += 15) push(d, 1);
        push(250, 0);
        send(8'd250);
        wait_idle();
        check("noclamp_final", duty, 250);
`endif

        // Reset in the middle of a ramp abandons it.
        apply_reset();
        step = 4'd1;
        push(129, 1); push(130, 1);
        send(8'd250);
        wait_q_empty();
        apply_reset();
        repeat (30) @(negedge clk);
        check("abandon_duty", duty, 128);
        check("abandon_busy", busy, 0);
        check("abandon_ready", tgt_ready, 1);

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/servo_ramp.md
SERVO_RAMP -- requirements
Module: servo_ramp

Interface
REQ-001 Parameter FRAME_CLKS, default 238000, clk cycles per position-update frame (>=2).
REQ-002 Parameter INIT_POS, default 128, duty_cycle_o value after reset.
REQ-003 Parameter MIN_POS, default 0, lower clamp bound, used only when SERVO_RAMP_CLAMP_EN is defined.
REQ-004 Parameter MAX_POS, default 255, upper clamp bound, used only when SERVO_RAMP_CLAMP_EN is defined; MIN_POS <= INIT_POS <= MAX_POS.
REQ-005 clk  input  1  clock.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 tgt_i  input  8  requested target position.
REQ-008 tgt_valid_i  input  1  tgt_i valid.
REQ-009 tgt_ready_o  output  1  block can accept a target.
REQ-010 step_i  input  4  maximum position change per frame; 0 treated as 1.
REQ-011 duty_cycle_o  output  8  registered position, feeds the servo PWM stage duty input.
REQ-012 busy_o  output  1  high while ramping.
REQ-013 frame_o  output  1  one-cycle pulse marking each frame boundary.

Function
REQ-014 Frame counter SHALL run freely from reset, count 0..FRAME_CLKS-1 and wrap to 0; frame_o SHALL be high exactly in the cycle the count equals FRAME_CLKS-1.
REQ-015 FSM states IDLE and RAMP; tgt_ready_o SHALL be 1 in IDLE, 0 in RAMP; busy_o SHALL be 1 exactly in RAMP.
REQ-016 Transfer SHALL occur on a clk edge with tgt_valid_i & tgt_ready_o; the target register SHALL latch tgt_i (after clamping, if enabled) on that edge.
REQ-017 On transfer, if the latched target differs from duty_cycle_o the FSM SHALL enter RAMP; otherwise it SHALL remain in IDLE.
REQ-018 In RAMP, on each edge where frame_o is high, duty_cycle_o SHALL move toward target by min(step, |target-duty|); step is step_i, or 1 if step_i = 0.
REQ-019 Arithmetic SHALL use 9-bit signed differences; duty_cycle_o SHALL never overshoot the target or wrap past 0 or 255.
REQ-020 When the updated duty_cycle_o equals target, the FSM SHALL return to IDLE on the same edge; tgt_ready_o SHALL be 1 on the following cycle.
REQ-021 A transfer coinciding with frame_o in IDLE SHALL NOT step duty_cycle_o on that edge; the first step SHALL occur at the next frame_o.
REQ-022 step_i SHALL be sampled at each frame edge, so mid-ramp changes take effect at the next step.
REQ-023 tgt_valid_i asserted during RAMP SHALL be ignored (no transfer), and tgt_i SHALL be held by the source until accepted.
REQ-024 duty_cycle_o SHALL change only on frame edges, never mid-frame.

Reset
REQ-025 While rst=0 at a clk edge: state IDLE, frame count 0, duty_cycle_o=INIT_POS, target=INIT_POS, busy_o=0, frame_o=0; tgt_ready_o SHALL be 1 from the first cycle after reset release.
REQ-026 Reset asserted mid-ramp SHALL abandon the ramp with no residual step after release.

Configuration
REQ-027 With SERVO_RAMP_CLAMP_EN defined, accepted targets SHALL be clamped to [MIN_POS, MAX_POS] before latching; without it, targets SHALL latch unmodified and MIN_POS/MAX_POS SHALL have no effect.

Structure
REQ-028 Package servo_pkg SHALL hold POS_W=8, STEP_W=4 and the FSM state enum, shared with the PWM stage.
REQ-029 Frame counter SHALL be a sub-module servo_frame_timer (ports clk, rst, frame_o; parameter FRAME_CLKS).

Verification (bench uses FRAME_CLKS=10)
REQ-030 Reset release -> duty_cycle_o=128, tgt_ready_o=1, busy_o=0, first frame_o pulse 10 cycles after release.
REQ-031 Target 138, step_i=3 -> duty 131,134,137,138 on four successive frames; busy_o falls with the 138 update.
REQ-032 Target 120, step_i=0 from 128 -> decrements by 1 per frame, eight frames, ends at 120.
REQ-033 Target 200 offered mid-ramp -> tgt_ready_o=0, no transfer; accepted on the first IDLE cycle, then ramps to 200.
REQ-034 Transfer of 255 aligned with frame_o, step_i=15 -> no change that edge; next frames give 143,158,...,248,255 with no wrap.
REQ-035 SERVO_RAMP_CLAMP_EN defined, MIN_POS=50, MAX_POS=200, target 250 -> target latched 200, ramp stops at 200; reset asserted mid-ramp -> duty_cycle_o=128 next cycle.
